// File: rtl/clap_pkg.sv
// Shared types and helpers for the clap detector.
package clap_pkg;

    // Detector FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLAP1   = 3'd1,
        GAP     = 3'd2,
        CLAP2   = 3'd3,
        NOISE   = 3'd4,
        HOLDOFF = 3'd5
    } state_t;

    // Bits needed to hold values 0..v-1 (minimum 1)
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clap_detector.sv
// Double-clap detector: watches per-frame energy, toggles the light on a
// loud / quiet-gap / loud pattern and pulses double_clap for one cycle.
module clap_detector
    import clap_pkg::*;
#(
    parameter int unsigned              ENERGY_WIDTH    = 32,
    parameter logic [ENERGY_WIDTH-1:0]  THRESHOLD       = 32'd1000000,
    parameter int unsigned              MAX_CLAP_FRAMES = 3,
    parameter int unsigned              GAP_MIN_FRAMES  = 2,
    parameter int unsigned              WINDOW_FRAMES   = 8,
    parameter int unsigned              HOLDOFF_FRAMES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ENERGY_WIDTH-1:0] energy_data,
    input  logic                    energy_valid,
    output logic                    energy_ready,
    output logic                    light,
    output logic                    double_clap,
    output logic                    busy
);

    localparam int unsigned CNT_MAX = max2(max2(MAX_CLAP_FRAMES, GAP_MIN_FRAMES),
                                           max2(WINDOW_FRAMES, HOLDOFF_FRAMES));
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CLAP_FRAMES);
    localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GAP_MIN_FRAMES);
    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF_FRAMES);

    if (GAP_MIN_FRAMES > WINDOW_FRAMES || MAX_CLAP_FRAMES < 1 || GAP_MIN_FRAMES < 1 ||
        WINDOW_FRAMES < 1 || HOLDOFF_FRAMES < 1) begin : g_param_check
        $error("clap_detector: invalid frame parameters");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             toggle;
    logic             accept;
    logic             loud;

    assign energy_ready = 1'b1;
    assign accept       = energy_valid && energy_ready;
    assign loud         = (energy_data >= THRESHOLD);

    // Next state, shared counter and detection strobe, advanced per accepted frame
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        toggle  = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (loud) begin
                        state_n = CLAP1;
                        cnt_n   = ONE;
                    end
                end
                CLAP1: begin
                    if (loud) begin
                        if (cnt == MAX_C) state_n = NOISE;
                        else              cnt_n   = cnt + ONE;
                    end else begin
                        state_n = GAP;
                        cnt_n   = ONE;
                    end
                end
                GAP: begin
                    if (!loud) begin
                        if (cnt == WIN_C) state_n = IDLE;
                        else              cnt_n   = cnt + ONE;
                    end else begin
                        state_n = (cnt >= GMIN_C) ? CLAP2 : CLAP1;
                        cnt_n   = ONE;
                    end
                end
                CLAP2: begin
                    if (loud) begin
                        if (cnt == MAX_C) state_n = NOISE;
                        else              cnt_n   = cnt + ONE;
                    end else begin
                        state_n = HOLDOFF;
                        cnt_n   = ONE;
                        toggle  = 1'b1;
                    end
                end
                NOISE: begin
                    if (!loud) state_n = IDLE;
                end
                HOLDOFF: begin
                    if (cnt == HOLD_C) state_n = IDLE;
                    else               cnt_n   = cnt + ONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            light       <= 1'b0;
            double_clap <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            light       <= light ^ toggle;
            double_clap <= toggle;
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_clap_detector.sv
// Scoreboard bench for clap_detector: directed frame vectors push expected
// outputs; a monitor pops and compares after every accepted frame.
module tb_clap_detector;
    import clap_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] energy_data;
    logic        energy_valid;
    logic        energy_ready;
    logic        light;
    logic        double_clap;
    logic        busy;

    typedef struct packed {
        logic       l;
        logic       dc;
        logic       b;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t got;
    logic acc_d;
    int   total = 0;
    int   bad   = 0;

    clap_detector #(
        .ENERGY_WIDTH   (32),
        .THRESHOLD      (32'd1000),
        .MAX_CLAP_FRAMES(3),
        .GAP_MIN_FRAMES (2),
        .WINDOW_FRAMES  (8),
        .HOLDOFF_FRAMES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .energy_data (energy_data),
        .energy_valid(energy_valid),
        .energy_ready(energy_ready),
        .light       (light),
        .double_clap (double_clap),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Issue one frame with its hand-computed result, then idle for gap cycles
    task automatic frame(input logic [31:0] e, input state_t st, input logic l,
                         input logic dc, input int gap);
        exp_t x;
        x.l  = l;
        x.dc = dc;
        x.b  = (st != IDLE);
        x.st = st;
        q.push_back(x);
        energy_data  = e;
        energy_valid = 1'b1;
        @(posedge clock);
        #1;
        energy_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Flags cycles whose rising edge accepted a frame
    always @(posedge clock or posedge reset) begin
        if (reset) acc_d <= 1'b0;
        else       acc_d <= energy_valid;
    end

    // Monitor: compare after each accepted frame, otherwise outputs must hold
    always @(negedge clock) begin
        if (reset) begin
            last = '0;
        end else if (acc_d) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: frame accepted with no expectation at %0t", $time);
            end else begin
                got = q.pop_front();
                chk("light", {31'd0, light}, {31'd0, got.l});
                chk("double_clap", {31'd0, double_clap}, {31'd0, got.dc});
                chk("busy", {31'd0, busy}, {31'd0, got.b});
                chk("state", {29'd0, dut.state}, {29'd0, got.st});
                last    = got;
                last.dc = 1'b0;
            end
        end else begin
            chk("hold_light", {31'd0, light}, {31'd0, last.l});
            chk("hold_double_clap", {31'd0, double_clap}, 32'd0);
            chk("hold_busy", {31'd0, busy}, {31'd0, last.b});
        end
    end

    initial begin
        reset        = 1'b1;
        energy_valid = 1'b0;
        energy_data  = '0;
        #1;
        chk("reset_light", {31'd0, light}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, energy_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic pair, then a pattern swallowed by holdoff, then a second toggle
        frame(5000, CLAP1,   0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        frame(5000, CLAP2,   0, 0, 0);
        frame(0,    HOLDOFF, 1, 1, 0);
        frame(5000, HOLDOFF, 1, 0, 0);
        frame(0,    HOLDOFF, 1, 0, 0);
        frame(0,    HOLDOFF, 1, 0, 0);
        frame(5000, IDLE,    1, 0, 0);
        frame(5000, CLAP1,   1, 0, 0);
        frame(0,    GAP,     1, 0, 0);
        frame(0,    GAP,     1, 0, 0);
        frame(5000, CLAP2,   1, 0, 0);
        frame(0,    HOLDOFF, 0, 1, 0);
        for (int i = 0; i < 3; i++) frame(0, HOLDOFF, 0, 0, 0);
        frame(0,    IDLE,    0, 0, 0);

        // Gap too short restarts as a fresh first clap
        frame(5000, CLAP1,   0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        frame(5000, CLAP1,   0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        for (int i = 0; i < 7; i++) frame(0, GAP, 0, 0, 0);
        frame(0,    IDLE,    0, 0, 0);

        // Window expiry after nine quiet frames
        frame(5000, CLAP1,   0, 0, 0);
        for (int i = 0; i < 8; i++) frame(0, GAP, 0, 0, 0);
        frame(0,    IDLE,    0, 0, 0);
        frame(5000, CLAP1,   0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        for (int i = 0; i < 7; i++) frame(0, GAP, 0, 0, 0);
        frame(0,    IDLE,    0, 0, 0);

        // Sustained noise
        frame(5000, CLAP1,   0, 0, 0);
        frame(5000, CLAP1,   0, 0, 0);
        frame(5000, CLAP1,   0, 0, 0);
        frame(5000, NOISE,   0, 0, 0);
        frame(5000, NOISE,   0, 0, 0);
        frame(0,    IDLE,    0, 0, 0);

        // Threshold edge: equality is loud, one below is quiet
        frame(1000, CLAP1,   0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        frame(0,    GAP,     0, 0, 0);
        frame(1000, CLAP2,   0, 0, 0);
        frame(0,    HOLDOFF, 1, 1, 0);
        for (int i = 0; i < 3; i++) frame(0, HOLDOFF, 1, 0, 0);
        frame(0,    IDLE,    1, 0, 0);
        frame(999,  IDLE,    1, 0, 0);
        frame(0,    IDLE,    1, 0, 0);
        frame(0,    IDLE,    1, 0, 0);
        frame(999,  IDLE,    1, 0, 0);
        frame(0,    IDLE,    1, 0, 0);

        // Asynchronous reset mid-GAP with light on
        frame(5000, CLAP1,   1, 0, 0);
        frame(0,    GAP,     1, 0, 0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_light", {31'd0, light}, 32'd0);
        chk("async_double_clap", {31'd0, double_clap}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_state", {29'd0, dut.state}, {29'd0, IDLE});
        chk("async_ready", {31'd0, energy_ready}, 32'd1);
        energy_data  = 5000;
        energy_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        energy_valid = 1'b0;
        reset        = 1'b0;

        // Basic pair with a valid every fifth cycle
        frame(5000, CLAP1,   0, 0, 4);
        frame(0,    GAP,     0, 0, 4);
        frame(0,    GAP,     0, 0, 4);
        frame(5000, CLAP2,   0, 0, 4);
        frame(0,    HOLDOFF, 1, 1, 4);
        for (int i = 0; i < 3; i++) frame(0, HOLDOFF, 1, 0, 4);
        frame(0,    IDLE,    1, 0, 4);

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clock);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
